// File: rtl/tea_pkg.sv
// tea_pkg: shared FSM encodings and default sizing for the TEA job scheduler.
package tea_pkg;
  localparam int WORD_SIZE_DEF = 16;
  localparam int TIMEOUT_DEF = 1023;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
endpackage

// File: rtl/tea_rr_arb2.sv
// tea_rr_arb2: two-way round-robin arbiter; priority moves to the loser on each update.
module tea_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       any
);
  logic prio;
  always_comb begin
    any = |req;
    grant = &req ? prio : req[1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio <= 1'b0;
    else if (update) prio <= ~grant;
  end
endmodule

// File: rtl/tea_scheduler.sv
// tea_scheduler: arbitrates two requesters onto one external TEA core with a watchdog.
module tea_scheduler
  import tea_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iKeyLoad,
  input  logic [4*WORD_SIZE-1:0] iKey,
  output logic                   oKeyReady,
  input  logic [1:0]             iReqValid,
  output logic [1:0]             oReqReady,
  input  logic [4*WORD_SIZE-1:0] iReqData,
  output logic                   oRspValid,
  input  logic                   iRspReady,
  output logic                   oRspId,
  output logic [2*WORD_SIZE-1:0] oRspData,
  output logic                   oRspErr,
  output logic                   oCoreStart,
  output logic [WORD_SIZE-1:0]   oCoreV0,
  output logic [WORD_SIZE-1:0]   oCoreV1,
  output logic [WORD_SIZE-1:0]   oCoreK0,
  output logic [WORD_SIZE-1:0]   oCoreK1,
  output logic [WORD_SIZE-1:0]   oCoreK2,
  output logic [WORD_SIZE-1:0]   oCoreK3,
  input  logic [WORD_SIZE-1:0]   iCoreC0,
  input  logic [WORD_SIZE-1:0]   iCoreC1,
  input  logic                   iCoreDone
);
  localparam int W = WORD_SIZE;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [1:0] state;
  logic [4*W-1:0] key;
  logic [2*W-1:0] pt;
  logic [WDW-1:0] wd;
  logic grant, any, take;
  tea_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req(iReqValid),
    .update(take),
    .grant(grant),
    .any(any)
  );
  // Reset also masks the grant pulse, since IDLE with a pending request would otherwise show ready.
  always_comb begin
    take = (state == S_IDLE) && any;
    oReqReady = (take && !rst) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    oKeyReady = state == S_IDLE;
    oCoreStart = state == S_RUN;
    oRspValid = state == S_RESP;
    {oCoreK3, oCoreK2, oCoreK1, oCoreK0} = key;
    {oCoreV1, oCoreV0} = pt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      key <= '0;
      pt <= '0;
      wd <= '0;
      oRspId <= 1'b0;
      oRspData <= '0;
      oRspErr <= 1'b0;
    end else if (state == S_IDLE) begin
      if (iKeyLoad) key <= iKey;
      if (take) begin
        pt <= grant ? iReqData[4*W-1:2*W] : iReqData[2*W-1:0];
        oRspId <= grant;
        state <= S_LOAD;
      end
    end else if (state == S_LOAD) begin
      wd <= '0;
      state <= S_RUN;
    end else if (state == S_RUN) begin
      wd <= wd + 1'b1;
      if (iCoreDone) begin
        oRspData <= {iCoreC1, iCoreC0};
        oRspErr <= 1'b0;
        state <= S_RESP;
      end else if (wd == WD_LAST) begin
        oRspData <= '0;
        oRspErr <= 1'b1;
        state <= S_RESP;
      end
    end else if (iRspReady) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_tea_scheduler.sv
// tb_tea_scheduler: table-driven job vectors plus hold, reset and timeout corner sequences.
module tb_tea_scheduler;
  typedef struct {
    logic        ld;
    logic [63:0] key;
    logic [1:0]  valid;
    logic [63:0] data;
    int          done_at;
    logic        id;
    logic [31:0] pt;
    logic [31:0] rsp;
    logic        err;
    int          lat;
  } vec_t;
  logic clk = 0, rst = 1;
  logic iKeyLoad = 0, iRspReady = 0;
  logic [63:0] iKey = '0, iReqData = '0;
  logic [1:0] iReqValid = '0;
  logic oKeyReady, oRspValid, oRspId, oRspErr, oCoreStart, iCoreDone;
  logic [1:0] oReqReady;
  logic [31:0] oRspData;
  logic [15:0] oCoreV0, oCoreV1, oCoreK0, oCoreK1, oCoreK2, oCoreK3;
  logic [15:0] iCoreC0 = 16'h1234, iCoreC1 = 16'h5678;
  logic [63:0] cur_key = '0;
  int done_at = -1, cnt = 0, checks = 0, passes = 0;
  vec_t vt[8];
  tea_scheduler dut (
    .clk(clk), .rst(rst), .iKeyLoad(iKeyLoad), .iKey(iKey), .oKeyReady(oKeyReady),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqData(iReqData),
    .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspId(oRspId), .oRspData(oRspData),
    .oRspErr(oRspErr), .oCoreStart(oCoreStart), .oCoreV0(oCoreV0), .oCoreV1(oCoreV1),
    .oCoreK0(oCoreK0), .oCoreK1(oCoreK1), .oCoreK2(oCoreK2), .oCoreK3(oCoreK3),
    .iCoreC0(iCoreC0), .iCoreC1(iCoreC1), .iCoreDone(iCoreDone)
  );
  always #5 clk = ~clk;
  // Core stub: cnt equals the number of RUN cycles already elapsed.
  always @(posedge clk or posedge rst)
    if (rst || !oCoreStart) cnt <= 0;
    else cnt <= cnt + 1;
  assign iCoreDone = oCoreStart && done_at >= 0 && cnt == done_at;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (!oRspValid && n < 1100) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask
  task automatic launch(input logic [1:0] valid, input logic [63:0] data, input int d);
    done_at = d;
    iReqValid = valid;
    iReqData = data;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    done_at = v.done_at;
    iReqValid = v.valid;
    iReqData = v.data;
    iKeyLoad = v.ld;
    iKey = v.key;
    if (v.ld) cur_key = v.key;
    #1;
    chk("grant", 64'(oReqReady), v.id ? 64'd2 : 64'd1);
    chk("idle_key_ready", 64'(oKeyReady), 64'd1);
    @(negedge clk);
    iKeyLoad = 0;
    #1;
    chk("load_req_ready", 64'(oReqReady), 64'd0);
    chk("load_start", 64'(oCoreStart), 64'd0);
    chk("load_pt", {32'd0, oCoreV1, oCoreV0}, {32'd0, v.pt});
    chk("key", {oCoreK3, oCoreK2, oCoreK1, oCoreK0}, cur_key);
    @(negedge clk);
    #1;
    chk("run_start", 64'(oCoreStart), 64'd1);
    wait_rsp(n);
    chk("latency", 64'(n), 64'(v.lat));
    chk("rsp_data", 64'(oRspData), 64'(v.rsp));
    chk("rsp_id", 64'(oRspId), 64'(v.id));
    chk("rsp_err", 64'(oRspErr), 64'(v.err));
    iRspReady = 1;
    @(negedge clk);
    #1;
    iRspReady = 0;
    iReqValid = 0;
    chk("rsp_done", 64'(oRspValid), 64'd0);
  endtask
  initial begin
    int n;
    logic seen;
    vt[0] = '{1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11, 64'h2222_1111_BBBB_AAAA, 19, 1'b0, 32'hBBBB_AAAA, 32'h5678_1234, 1'b0, 20};
    vt[1] = '{1'b0, 64'h0, 2'b11, 64'h2222_1111_BBBB_AAAA, 19, 1'b1, 32'h2222_1111, 32'h5678_1234, 1'b0, 20};
    vt[2] = '{1'b0, 64'h0, 2'b11, 64'h2222_1111_BBBB_AAAA, 19, 1'b0, 32'hBBBB_AAAA, 32'h5678_1234, 1'b0, 20};
    vt[3] = '{1'b0, 64'h0, 2'b11, 64'h2222_1111_BBBB_AAAA, 19, 1'b1, 32'h2222_1111, 32'h5678_1234, 1'b0, 20};
    vt[4] = '{1'b1, 64'h0004_0003_0002_0001, 2'b01, 64'h0000_0000_BEEF_CAFE, 19, 1'b0, 32'hBEEF_CAFE, 32'h5678_1234, 1'b0, 20};
    vt[5] = '{1'b0, 64'h0, 2'b10, 64'h9999_8888_0000_0000, 5, 1'b1, 32'h9999_8888, 32'h5678_1234, 1'b0, 6};
    vt[6] = '{1'b0, 64'h0, 2'b01, 64'h0000_0000_1357_2468, -1, 1'b0, 32'h1357_2468, 32'h0, 1'b1, 1023};
    vt[7] = '{1'b0, 64'h0, 2'b01, 64'h0000_0000_7777_6666, 1022, 1'b0, 32'h7777_6666, 32'h5678_1234, 1'b0, 1023};
    iReqValid = 2'b11;
    #3;
    chk("rst_req_ready", 64'(oReqReady), 64'd0);
    chk("rst_start", 64'(oCoreStart), 64'd0);
    chk("rst_rsp", {oRspValid, oRspErr, oRspId, oRspData}, 64'd0);
    chk("rst_key", {oCoreK3, oCoreK2, oCoreK1, oCoreK0}, 64'd0);
    chk("rst_key_ready", 64'(oKeyReady), 64'd1);
    @(negedge clk);
    rst = 0;
    iReqValid = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(vt[i]);
    launch(2'b01, 64'h0000_0000_0F0F_F0F0, 19);
    wait_rsp(n);
    iReqValid = 2'b11;
    iKeyLoad = 1;
    iKey = 64'hFFFF_EEEE_DDDD_CCCC;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 64'(oRspValid), 64'd1);
      chk("hold_data", 64'(oRspData), 64'h5678_1234);
      chk("hold_id_err", {oRspId, oRspErr}, 64'd0);
      chk("hold_req_ready", 64'(oReqReady), 64'd0);
      @(negedge clk);
      #1;
    end
    chk("hold_key", {oCoreK3, oCoreK2, oCoreK1, oCoreK0}, cur_key);
    iKeyLoad = 0;
    iReqValid = 0;
    iRspReady = 1;
    @(negedge clk);
    iRspReady = 0;
    launch(2'b01, 64'h0000_0000_ABCD_0123, 19);
    repeat (5) @(negedge clk);
    iReqValid = 2'b11;
    rst = 1;
    #1;
    chk("mid_rst_start", 64'(oCoreStart), 64'd0);
    chk("mid_rst_req_ready", 64'(oReqReady), 64'd0);
    chk("mid_rst_rsp", {oRspValid, oRspErr, oRspId, oRspData}, 64'd0);
    chk("mid_rst_key", {oCoreK3, oCoreK2, oCoreK1, oCoreK0}, 64'd0);
    chk("mid_rst_pt", {32'd0, oCoreV1, oCoreV0}, 64'd0);
    @(negedge clk);
    rst = 0;
    iReqValid = 0;
    cur_key = '0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen |= oRspValid;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);
    run_vec('{1'b0, 64'h0, 2'b11, 64'h4444_3333_2222_1111, 19, 1'b0, 32'h2222_1111, 32'h5678_1234, 1'b0, 20});
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tea_scheduler.md
TEA_SCHEDULER -- requirements
Module: tea_scheduler

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, which sets the width of each data/key word (W below).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, which sets the maximum number of RUN cycles before a job is aborted.
REQ-003 Ports SHALL be as follows:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- iKeyLoad  in  1  key write strobe
- iKey  in  4W  {K3,K2,K1,K0}, K0 at LSBs
- oKeyReady  out  1  high when a key write is accepted
- iReqValid  in  2  per-requester job valid
- oReqReady  out  2  per-requester job accept
- iReqData  in  4W  requester r's {V1,V0} at bits [2W*r +: 2W]
- oRspValid  out  1  result valid
- iRspReady  in  1  result accept
- oRspId  out  1  id of the requester that owns the result
- oRspData  out  2W  {C1,C0}
- oRspErr  out  1  job timed out
- oCoreStart  out  1  cipher core start (level-held)
- oCoreV0, oCoreV1  out  W each  plaintext to the core
- oCoreK0..oCoreK3  out  W each  key to the core
- iCoreC0, iCoreC1  in  W each  ciphertext from the core
- iCoreDone  in  1  core finished

Function
REQ-004 The FSM SHALL have exactly the states IDLE, LOAD, RUN and RESP.
REQ-005 In IDLE, oKeyReady SHALL be 1; iKeyLoad in IDLE SHALL latch iKey into the key registers; iKeyLoad in any other state SHALL be ignored.
REQ-006 In IDLE, when any iReqValid bit is 1, the arbiter SHALL grant one requester g, drive oReqReady[g]=1 combinationally for that cycle only, latch the requester's data and g, and move to LOAD.
- If iKeyLoad and a request coincide, the new key SHALL apply to that job.
REQ-007 Arbitration SHALL be two-way round-robin.
- A single valid requester SHALL win.
- When both are valid, pointer rPrio SHALL win.
- On each grant, rPrio SHALL become the non-granted index.
REQ-008 oReqReady SHALL be 0 in every state except IDLE.
REQ-009 In LOAD, oCoreStart SHALL be 0 with oCoreV0/V1 driving the latched plaintext, so the core loads it; the FSM SHALL then go to RUN unconditionally.
REQ-010 In RUN, oCoreStart SHALL be 1 and the watchdog counter (cleared on entry) SHALL increment every cycle.
REQ-011 In RUN, iCoreDone=1 SHALL latch {iCoreC1,iCoreC0} into oRspData, set oRspErr=0 and move to RESP.
REQ-012 In RUN, watchdog==TIMEOUT_CYCLES-1 with iCoreDone=0 SHALL set oRspData=0 and oRspErr=1, then move to RESP.
- If iCoreDone and timeout coincide, done SHALL take priority.
REQ-013 In RESP, oCoreStart SHALL be 0 (this clears the core) and oRspValid SHALL be 1 while oRspData, oRspId and oRspErr are held stable.
- iRspReady=1 SHALL complete the handshake and return the FSM to IDLE.
REQ-014 oRspValid SHALL be 1 only in RESP; a new grant SHALL occur no earlier than the cycle after the response handshake.
REQ-015 Latency SHALL be: accept in cycle T, oCoreStart rising at T+2, oRspValid rising one cycle after iCoreDone is sampled high.
REQ-016 oCoreK0..K3 SHALL continuously drive the key registers, and oCoreV0/V1 SHALL continuously drive the latched plaintext.
REQ-017 The watchdog SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL never wrap.

Reset
REQ-018 rst SHALL asynchronously force the following:
- state=IDLE, rPrio=0
- key, plaintext, watchdog and response registers = 0
- oCoreStart=0, oRspValid=0, oRspErr=0, oRspId=0, oReqReady=0
REQ-019 rst asserted mid-job SHALL abort the job with no response and leave oCoreStart=0, which clears the core.

Structure
REQ-020 State encodings and the default WORD_SIZE/TIMEOUT_CYCLES values SHALL reside in a shared package, tea_pkg.
REQ-021 Arbitration SHALL be a sub-module, tea_rr_arb2: inputs req[1:0] and update strobe; outputs grant index and any-grant.
REQ-022 The cipher core SHALL be external to this block, connected through the oCore*/iCore* ports.

Verification (bench uses a core stub that asserts iCoreDone 20 cycles after oCoreStart rises and returns C0=16'h1234, C1=16'h5678)
REQ-023 Key then job: key 16'h0001..0004, req0 {V1,V0}={16'hBEEF,16'hCAFE} -> oCoreK0..K3=1..4, oCoreV0=16'hCAFE in LOAD, oRspData=32'h56781234, Id=0, Err=0.
REQ-024 Both valid every cycle for 4 jobs -> grant order 0,1,0,1.
REQ-025 Stub never asserts done, TIMEOUT_CYCLES=1023 -> oRspErr=1 and oRspData=0 exactly 1023 RUN cycles after oCoreStart rises.
REQ-026 iRspReady held 0 for 10 cycles -> oRspValid and data stable; no oReqReady pulse; iKeyLoad ignored (key unchanged).
REQ-027 rst pulsed during RUN -> all outputs at reset values immediately, no response; next job completes normally.
REQ-028 iCoreDone rises in the same cycle the watchdog reaches its limit -> oRspErr=0 and oRspData=32'h56781234.
